// File: rtl/sample_stream_pkg.sv
// ---------------------------------------------------------------------------
// sample_stream_pkg
// Shared definitions for the sample/filter UART streamer:
//   SYNC_BYTE    - first byte of every frame, lets the host resynchronise
//   FRAME_BYTES  - bytes per frame (sync + raw hi/lo + filt hi/lo)
//   uart_state_t - transmitter states
//   frame_byte() - picks byte N (0 = sync byte) out of a 40-bit frame word
// ---------------------------------------------------------------------------
package sample_stream_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 5;
    localparam int         FRAME_BITS  = FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Byte 0 is the most significant byte so the frame goes out in the
    // order sync, raw[15:8], raw[7:0], filt[15:8], filt[7:0].
    function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame,
                                              input logic [2:0]            idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = frame[39:32];
            3'd1:    b = frame[31:24];
            3'd2:    b = frame[23:16];
            3'd3:    b = frame[15:8];
            default: b = frame[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sample_uart_streamer_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a combinational head (rd_data shows the oldest
// entry whenever the FIFO is not empty).
//   clk, rst  - clock, synchronous active-high reset (flushes pointers/count)
//   wr_en     - write request, ignored while full
//   wr_data   - data to write
//   rd_en     - pop request, ignored while empty
//   rd_data   - current head entry
//   full      - count == DEPTH
//   empty     - count == 0
//   count     - exact registered occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Full/empty come from the registered count, so a write while full is
    // refused even if a pop happens on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop
    // leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sample_uart_streamer.sv
// ---------------------------------------------------------------------------
// sample_uart_streamer
// Captures {raw, filtered} sample pairs into a FIFO and sends each pair over
// an 8N1 UART as a 5-byte frame: A5, raw hi, raw lo, filt hi, filt lo.
//   clk        - system clock
//   rst        - synchronous active-high reset; aborts any frame in flight
//   in_valid   - capture strobe, one pair per high cycle
//   raw_in     - unfiltered sample
//   filt_in    - filtered sample
//   tx         - registered UART line, idles high
//   busy       - high whenever the transmitter is not IDLE
//   overflow   - sticky, set when a pair is dropped on a full FIFO
//   fifo_count - current FIFO occupancy
// ---------------------------------------------------------------------------
module sample_uart_streamer
    import sample_stream_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [15:0]                 raw_in,
    input  logic [15:0]                 filt_in,
    output logic                        tx,
    output logic                        busy,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BYTE = 3'(FRAME_BYTES - 1);

    uart_state_t           state;
    logic [CNT_W-1:0]      baud_cnt;
    logic [2:0]            bit_idx;
    logic [2:0]            byte_idx;
    logic [FRAME_BITS-1:0] frame_reg;
    logic [31:0]           fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop;
    logic                  baud_done;
    logic [7:0]            cur_byte;

    // The head is taken the same cycle the transmitter sits in IDLE with
    // data waiting, which gives exactly one IDLE cycle between frames.
    assign pop       = (state == IDLE) && !fifo_empty;
    assign baud_done = (baud_cnt == BAUD_LAST);
    assign cur_byte  = frame_byte(frame_reg, byte_idx);
    assign busy      = (state != IDLE);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data ({raw_in, filt_in}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Sticky drop flag; the full test uses the pre-edge count, matching
    // the FIFO's own write gating.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (in_valid && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    // Transmitter FSM. tx is registered from the current state, so the line
    // trails the state by one cycle: tx drops one edge after the pop and the
    // final stop bit merges with the IDLE cycle that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            frame_reg <= '0;
            tx        <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        frame_reg <= {SYNC_BYTE, fifo_rd_data};
                        byte_idx  <= '0;
                        state     <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    tx <= cur_byte[bit_idx];
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (byte_idx < LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_uart_streamer.sv
// ---------------------------------------------------------------------------
// tb_sample_uart_streamer
// Self-checking bench for sample_uart_streamer with CLKS_PER_BIT=4 and
// FIFO_DEPTH=4. A queue/timer reference model predicts occupancy, busy and
// overflow every cycle; a UART receiver decodes tx and matches each frame
// against the pairs the model says were popped.
// ---------------------------------------------------------------------------
module tb_sample_uart_streamer;

    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 50 * CPB;
    localparam int HALF      = CPB / 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] raw_in;
    logic [15:0] filt_in;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_checks;
    int n_fail;

    // Reference model state: pairs waiting, pairs on their way over the wire,
    // cycles left in the current frame and the sticky drop flag.
    logic [31:0] m_q[$];
    logic [31:0] m_sent[$];
    int          m_timer;
    logic        m_ovf;
    logic        check_en;

    // UART receiver state.
    logic        dec_active;
    int          dec_cnt;
    logic [7:0]  dec_shift;
    logic [7:0]  rx_q[$];
    int          frames_rx;
    logic [39:0] last_frame;

    typedef struct {
        logic        valid;
        logic [15:0] raw;
        logic [15:0] filt;
        logic [2:0]  exp_count;
        logic        exp_ovf;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[7];

    sample_uart_streamer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .raw_in     (raw_in),
        .filt_in    (filt_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pushPair(input logic [15:0] r, input logic [15:0] f);
        in_valid = 1'b1;
        raw_in   = r;
        filt_in  = f;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid = v.valid;
        raw_in   = v.raw;
        filt_in  = v.filt;
        tick(1);
        checkOutput("vec_count", fifo_count, v.exp_count);
        checkOutput("vec_overflow", overflow, v.exp_ovf);
        checkOutput("vec_busy", busy, v.exp_busy);
    endtask

    // Wait until both model and DUT are quiet and every popped pair has
    // been seen on the wire; an expired budget counts as a failure.
    task automatic waitDrain(input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (m_timer == 0 && m_q.size() == 0 && m_sent.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            tick(1);
        end
        checkOutput("drain_done", done, 1'b1);
    endtask

    // Reference model: a frame occupies the transmitter for 50 bit times
    // from the pop; a pop needs an idle transmitter and a non-empty queue;
    // a push is refused when the queue held DEPTH pairs before the edge.
    always @(posedge clk) begin
        int pre;
        if (rst) begin
            m_q.delete();
            m_sent.delete();
            m_timer = 0;
            m_ovf   = 1'b0;
        end else begin
            pre = m_q.size();
            if (m_timer == 0 && pre > 0) begin
                m_sent.push_back(m_q.pop_front());
                m_timer = FRAME_CYC;
            end else if (m_timer > 0) begin
                m_timer--;
            end
            if (in_valid) begin
                if (pre < DEPTH) m_q.push_back({raw_in, filt_in});
                else             m_ovf = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of the status outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_busy", busy, (m_timer != 0));
            checkOutput("cyc_count", fifo_count, m_q.size());
            checkOutput("cyc_overflow", overflow, m_ovf);
            if (m_timer == 0) checkOutput("cyc_idle_tx", tx, 1'b1);
        end
    end

    // UART receiver: sample mid-bit, collect bytes, and every five bytes
    // compare the frame with the oldest pair the model has popped.
    always @(negedge clk) begin
        int j;
        logic [31:0] exp_pair;
        logic [39:0] frame;
        if (rst) begin
            dec_active = 1'b0;
            dec_cnt    = 0;
            rx_q.delete();
        end else if (!dec_active) begin
            if (tx === 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt >= HALF && ((dec_cnt - HALF) % CPB) == 0) begin
                j = (dec_cnt - HALF) / CPB;
                if (j == 0) begin
                    checkOutput("start_bit", tx, 1'b0);
                end else if (j <= 8) begin
                    dec_shift[j-1] = tx;
                end else begin
                    checkOutput("stop_bit", tx, 1'b1);
                    dec_active = 1'b0;
                    rx_q.push_back(dec_shift);
                    if (rx_q.size() == 5) begin
                        frame = {rx_q[0], rx_q[1], rx_q[2], rx_q[3], rx_q[4]};
                        rx_q.delete();
                        frames_rx++;
                        last_frame = frame;
                        if (m_sent.size() == 0) begin
                            checkOutput("unexpected_frame", frame, 40'h0);
                        end else begin
                            exp_pair = m_sent.pop_front();
                            checkOutput("frame", frame, {8'hA5, exp_pair});
                        end
                    end
                end
            end
        end
    end

    initial begin
        int busy_cycles;
        int gap;
        int frames0;
        int lows;
        logic [15:0] ra;
        logic [15:0] fa;

        n_checks  = 0;
        n_fail    = 0;
        frames_rx = 0;
        last_frame = '0;
        check_en  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        raw_in    = '0;
        filt_in   = '0;

        // Burst of six captures into an idle streamer: the first pair pops
        // on the second edge, the sixth hits a full FIFO and is dropped.
        for (int i = 0; i < 6; i++) begin
            vecs[i].valid = 1'b1;
            vecs[i].raw   = 16'(i);
            vecs[i].filt  = 16'(16'h0100 + i);
        end
        vecs[6].valid = 1'b0; vecs[6].raw = '0; vecs[6].filt = '0;
        vecs[0].exp_count = 3'd1; vecs[0].exp_ovf = 1'b0; vecs[0].exp_busy = 1'b0;
        vecs[1].exp_count = 3'd1; vecs[1].exp_ovf = 1'b0; vecs[1].exp_busy = 1'b1;
        vecs[2].exp_count = 3'd2; vecs[2].exp_ovf = 1'b0; vecs[2].exp_busy = 1'b1;
        vecs[3].exp_count = 3'd3; vecs[3].exp_ovf = 1'b0; vecs[3].exp_busy = 1'b1;
        vecs[4].exp_count = 3'd4; vecs[4].exp_ovf = 1'b0; vecs[4].exp_busy = 1'b1;
        vecs[5].exp_count = 3'd4; vecs[5].exp_ovf = 1'b1; vecs[5].exp_busy = 1'b1;
        vecs[6].exp_count = 3'd4; vecs[6].exp_ovf = 1'b1; vecs[6].exp_busy = 1'b1;

        tick(3);
        rst      = 1'b0;
        check_en = 1'b1;
        checkOutput("reset_tx", tx, 1'b1);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_overflow", overflow, 1'b0);
        checkOutput("reset_count", fifo_count, 3'd0);
        tick(2);

        $display("[TB] single pair latency and frame length");
        pushPair(16'h1234, 16'h0ABC);
        tick(1);
        checkOutput("t1_tx_before_fall", tx, 1'b1);
        busy_cycles = busy ? 1 : 0;
        tick(1);
        checkOutput("t1_tx_fall", tx, 1'b0);
        for (int i = 0; i < 400 && busy; i++) begin
            busy_cycles++;
            tick(1);
        end
        checkOutput("t1_busy_len", busy_cycles, FRAME_CYC);
        checkOutput("t1_tx_end", tx, 1'b1);
        checkOutput("t1_count_end", fifo_count, 3'd0);
        tick(5);
        checkOutput("t1_frames", frames_rx, 1);
        checkOutput("t1_frame_bytes", last_frame, 40'hA512340ABC);

        $display("[TB] second pair queued during a frame");
        ra = 16'($urandom);
        fa = 16'($urandom);
        pushPair(ra, fa);
        for (int i = 0; i < 10 && tx; i++) tick(1);
        checkOutput("t3_first_fall", tx, 1'b0);
        for (int i = 1; i <= 195; i++) begin
            if (i == 50) begin
                in_valid = 1'b1;
                raw_in   = 16'h5A5A;
                filt_in  = 16'hC3C3;
            end else if (i == 51) begin
                in_valid = 1'b0;
            end
            tick(1);
        end
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx) gap++;
            else break;
        end
        checkOutput("t3_gap", gap, CPB + 1);
        checkOutput("t3_count_after_pop", fifo_count, 3'd0);
        waitDrain(400);
        checkOutput("t3_frame2", last_frame, 40'hA55A5AC3C3);

        $display("[TB] burst into a full FIFO");
        frames0 = frames_rx;
        foreach (vecs[i]) applyStimulus(vecs[i]);
        in_valid = 1'b0;
        waitDrain(1500);
        checkOutput("t2_frames", frames_rx - frames0, 5);
        checkOutput("t2_last_frame", last_frame, 40'hA500040104);

        $display("[TB] sticky overflow across later frames");
        checkOutput("t5_ovf_after_drain", overflow, 1'b1);
        frames0 = frames_rx;
        pushPair(16'hBEEF, 16'h0042);
        waitDrain(400);
        checkOutput("t5_ovf_held", overflow, 1'b1);
        checkOutput("t5_frames", frames_rx - frames0, 1);

        $display("[TB] reset mid-frame with entries queued");
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            raw_in   = 16'(16'h7000 + i);
            filt_in  = 16'(16'h8000 + i);
            tick(1);
        end
        in_valid = 1'b0;
        checkOutput("t4_queued", fifo_count, 3'd2);
        tick(58);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("t4_tx", tx, 1'b1);
        checkOutput("t4_busy", busy, 1'b0);
        checkOutput("t4_count", fifo_count, 3'd0);
        checkOutput("t4_overflow", overflow, 1'b0);
        frames0 = frames_rx;
        lows    = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        checkOutput("t4_line_quiet", lows, 0);
        checkOutput("t4_no_frames", frames_rx - frames0, 0);

        $display("[TB] pointer wrap with spaced pairs");
        frames0 = frames_rx;
        for (int i = 0; i < 10; i++) begin
            pushPair(16'(16'h1000 + i * 16'h0111), 16'(16'hF00F ^ (i * 16'h0203)));
            tick(249);
        end
        waitDrain(400);
        checkOutput("t6_frames", frames_rx - frames0, 10);
        checkOutput("t6_overflow", overflow, 1'b0);

        $display("[TB] randomized captures against the model");
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom_range(0, 99) < 2);
            raw_in   = 16'($urandom);
            filt_in  = 16'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        waitDrain(2000);
        checkOutput("final_rx_idle", dec_active, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
